// File: rtl/nor_seq_pkg.sv
// Shared widths, instruction layout and FSM states for the NOR netlist sequencer.
package nor_seq_pkg;

  localparam int unsigned NIN_D        = 8;
  localparam int unsigned NCELLS_D     = 128;
  localparam int unsigned PROG_DEPTH_D = 128;
  localparam int unsigned CW           = $clog2(NCELLS_D);
  localparam int unsigned PW           = $clog2(PROG_DEPTH_D);
  localparam int unsigned IW           = 4*CW + 3;

  localparam int unsigned SC_LSB   = 0;
  localparam int unsigned SB_LSB   = CW;
  localparam int unsigned SA_LSB   = 2*CW;
  localparam int unsigned DST_LSB  = 3*CW;
  localparam int unsigned NSRC_LSB = 4*CW;
  localparam int unsigned LAST_BIT = 4*CW + 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INIT,
    EVAL,
    DONE
  } state_t;

  typedef struct packed {
    logic          last;
    logic [1:0]    nsrc;
    logic [CW-1:0] dst;
    logic [CW-1:0] src_a;
    logic [CW-1:0] src_b;
    logic [CW-1:0] src_c;
  } instr_t;

endpackage

// File: rtl/nor_prog_mem.sv
// Instruction store: synchronous write, combinational read at the program counter.
module nor_prog_mem #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned W     = 31,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nor_netlist_sequencer.sv
// Steps a stored NOR program over a bit-cell array, one INIT/EVAL pair per instruction.
module nor_netlist_sequencer
  import nor_seq_pkg::*;
#(
  parameter int unsigned NIN        = NIN_D,
  parameter int unsigned NCELLS     = NCELLS_D,
  parameter int unsigned PROG_DEPTH = PROG_DEPTH_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [PW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NIN-1:0] in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_z,
  output logic          busy,
  output logic          err
);

  state_t            state_q, state_d;
  logic [PW-1:0]     pc_q;
  logic [NCELLS-1:0] cells_q;
  logic [NIN-1:0]    x_q;
  logic              nor_q;
  logic              out_z_q;
  logic              err_q;
  logic [IW-1:0]     mem_rd;
  instr_t            ins;
  logic              src_or;
  logic              at_end;

  nor_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .W     (IW),
    .AW    (PW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (prog_we && (state_q == IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (mem_rd)
  );

  assign ins    = instr_t'(mem_rd);
  assign at_end = ins.last || (pc_q == PW'(PROG_DEPTH - 1));

  always_comb begin
    src_or = cells_q[ins.src_a];
    if (ins.nsrc >= 2'd2) src_or = src_or | cells_q[ins.src_b];
    if (ins.nsrc == 2'd3) src_or = src_or | cells_q[ins.src_c];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = LOAD;
      LOAD:    state_d = INIT;
      INIT:    state_d = EVAL;
      EVAL:    state_d = at_end ? DONE : INIT;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The NOR is sampled during INIT, before dst is forced high, so a source
  // aliasing dst still sees its pre-INIT value in EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cells_q <= '0;
      x_q     <= '0;
      nor_q   <= 1'b0;
      out_z_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) x_q <= in_x;
        LOAD: begin
          cells_q[NIN-1:0] <= x_q;
          pc_q             <= '0;
        end
        INIT: begin
          cells_q[ins.dst] <= 1'b1;
          nor_q            <= ~src_or;
        end
        EVAL: begin
          cells_q[ins.dst] <= nor_q;
          if (at_end) begin
            out_z_q <= nor_q;
            if (!ins.last) err_q <= 1'b1;
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == LOAD) || (state_q == INIT) || (state_q == EVAL);
  assign out_z     = out_z_q;
  assign err       = err_q;

endmodule

// File: tb/tb_nor_netlist_sequencer.sv
// Bench for nor_netlist_sequencer: a program-interpreting cell model predicts result, err and latency.
module tb_nor_netlist_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [6:0]  prog_addr;
  logic [30:0] prog_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic        out_valid;
  logic        out_ready;
  logic        out_z;
  logic        busy;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  logic [30:0] prog_img [128];
  bit          m_cells  [128];
  bit          m_err;

  nor_netlist_sequencer #(
    .NIN        (8),
    .NCELLS     (128),
    .PROG_DEPTH (128)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [30:0] mk(input bit last, input int ns, input int d, input int a,
                                     input int b, input int c);
    return {last, 2'(ns), 7'(d), 7'(a), 7'(b), 7'(c)};
  endfunction

  // Sequential interpretation of the program; cells persist between runs.
  task automatic model_run(input logic [7:0] x, output bit z, output int n);
    int pc;
    logic [30:0] w;
    int ns;
    bit v;
    for (int i = 0; i < 8; i++) m_cells[i] = x[i];
    pc = 0;
    n  = 0;
    z  = 0;
    forever begin
      w  = prog_img[pc];
      ns = int'(w[29:28]);
      v  = !(m_cells[w[20:14]] || (ns >= 2 && m_cells[w[13:7]]) || (ns == 3 && m_cells[w[6:0]]));
      m_cells[w[27:21]] = v;
      n++;
      if (w[30]) begin z = v; break; end
      if (pc == 127) begin z = v; m_err = 1; break; end
      pc++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_cells[i] = 0;
    m_err = 0;
  endtask

  task automatic write_prog(input int addr, input logic [30:0] data);
    prog_we   = 1'b1;
    prog_addr = 7'(addr);
    prog_data = data;
    @(posedge clk); #1;
    prog_we = 1'b0;
    prog_img[addr] = data;
  endtask

  // One transaction: accept, wait for DONE, hold for 'hold' cycles, release.
  task automatic run_vec(input logic [7:0] x, input int hold, input bit poke,
                         output bit z_act, output int lat);
    bit   z_exp;
    int   n;
    logic z_hold;
    model_run(x, z_exp, n);
    check("in_ready_idle", in_ready, 1);
    in_x     = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    if (poke) begin
      prog_we   = 1'b1;
      prog_addr = 7'd0;
      prog_data = 31'($urandom);
    end
    while (!out_valid && lat < 400) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) check("busy_while_running", {busy, in_ready}, 2'b10);
      @(posedge clk); #1;
      prog_we = 1'b0;
      lat++;
    end
    prog_we = 1'b0;
    check("out_valid_reached", out_valid, 1);
    check("latency", lat, 2 + 2*n);
    check("out_z", out_z, z_exp);
    check("err", err, m_err);
    z_act  = out_z;
    z_hold = out_z;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid_z_ready_busy", {out_valid, out_z, in_ready, busy}, {1'b1, z_hold, 1'b0, 1'b0});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after_accept", {out_valid, in_ready}, 2'b01);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_outputs", {out_valid, in_ready, busy, err, out_z}, 5'b01000);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic int emit_xor(input int base, input int a, input int b, input int d,
                                  input bit last);
    prog_img[base]   = mk(0, 2, 8,  a, b, 0);
    prog_img[base+1] = mk(0, 2, 9,  a, 8, 0);
    prog_img[base+2] = mk(0, 2, 10, b, 8, 0);
    prog_img[base+3] = mk(0, 2, 11, 9, 10, 0);
    prog_img[base+4] = mk(last, 1, d, 11, 0, 0);
    return base + 5;
  endfunction

  task automatic load_img(input int count);
    logic [30:0] w;
    for (int i = 0; i < count; i++) begin
      w = prog_img[i];
      write_prog(i, w);
    end
  endtask

  initial begin
    bit z;
    int lat;
    int idx;
    int acc;
    int plen;
    logic [7:0] x;

    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    #3;
    do_reset();

    // Single NOT
    write_prog(0, mk(1, 1, 8, 0, 0, 0));
    run_vec(8'h01, 0, 0, z, lat);
    check("not_x01_literal", {z, 8'(lat)}, {1'b0, 8'd4});
    run_vec(8'h00, 0, 0, z, lat);
    check("not_x00_literal", z, 1);

    // XOR(x0,x1) in five NORs
    idx = emit_xor(0, 0, 1, 12, 1);
    load_img(idx);
    run_vec(8'h01, 0, 0, z, lat);
    check("xor_01_literal", {z, 8'(lat)}, {1'b1, 8'd12});
    run_vec(8'h03, 0, 0, z, lat);
    check("xor_03_literal", {z, 8'(lat)}, {1'b0, 8'd12});

    // Backpressure, with a dropped program write mid-run
    run_vec(8'h02, 5, 1, z, lat);
    check("bp_literal", z, 1);
    run_vec(8'h02, 0, 0, z, lat);
    check("bp_rerun_literal", z, 1);

    // Reset mid-EVAL
    in_x = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {out_valid, busy, in_ready, err}, 4'b0010);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(8'h02, 0, 0, z, lat);
    check("after_reset_literal", z, 1);

    // rd84 f1 (LSB of the ones count) as a chain of seven XORs
    idx = 0;
    acc = 0;
    for (int i = 1; i < 8; i++) begin
      idx = emit_xor(idx, acc, i, 20 + i, (i == 7));
      acc = 20 + i;
    end
    load_img(idx);
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      run_vec(x, 0, 0, z, lat);
      check("rd84f1_golden", z, $countones(x) & 1);
    end
    check("rd84_err", err, 0);

    // Random programs, including dst on input cells and aliased sources
    for (int p = 0; p < 6; p++) begin
      plen = $urandom_range(1, 10);
      for (int i = 0; i < plen; i++)
        prog_img[i] = mk(i == plen - 1, $urandom_range(0, 3), $urandom_range(0, 31),
                         $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      load_img(plen);
      for (int k = 0; k < 8; k++) begin
        x = 8'($urandom);
        run_vec(x, $urandom_range(0, 3), 0, z, lat);
      end
    end

    // Missing last flag runs off the end; err is sticky until reset
    for (int i = 0; i < 128; i++) prog_img[i] = mk(0, 1, 8, 0, 0, 0);
    load_img(128);
    run_vec(8'h00, 0, 0, z, lat);
    check("runoff_literal", {err, 16'(lat)}, {1'b1, 16'd258});
    write_prog(0, mk(1, 1, 8, 0, 0, 0));
    run_vec(8'h01, 0, 0, z, lat);
    check("err_sticky_literal", err, 1);
    do_reset();
    check("err_cleared", err, 0);
    run_vec(8'h00, 0, 0, z, lat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nor_netlist_sequencer.md
Name: nor_netlist_sequencer

Overview:
- Cycle-stepped executor for the 8-input NOR-only netlists we generate, such as the rd84 symmetric-function family.
- Emulates MAGIC crossbar execution: each NOR is an INIT (output cell set to 1) followed by an EVAL (cell conditionally reset).
- Sits directly upstream of the evaluated netlist's consumer. It accepts an 8-bit input vector, runs the stored NOR program over a bit-cell array and returns one result bit.
- Used to validate NOR mappings and their step counts against golden models.

Parameters:
NIN, 8, number of primary inputs; loaded into cells 0..NIN-1
NCELLS, 128, bit-cell array size; cell address width CW = clog2(NCELLS) = 7
PROG_DEPTH, 128, instruction memory depth; PC width PW = clog2(PROG_DEPTH)
IW, 4*CW+3, instruction width, 31 at defaults

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
prog_we  in  1  program write strobe; honoured only in IDLE
prog_addr  in  PW  program write address
prog_data  in  IW  instruction word {last, nsrc[1:0], dst, srcA, srcB, srcC}
in_valid  in  1  input vector valid
in_ready  out  1  high only in IDLE
in_x  in  NIN  input vector; bit i goes to cell i
out_valid  out  1  result valid; high only in DONE
out_ready  in  1  consumer accepts the result
out_z  out  1  value of the last instruction's dst cell
busy  out  1  high in LOAD, INIT or EVAL
err  out  1  sticky: the program ran off its end; cleared only by reset

Behaviour:
Reset (asynchronous, rst_n=0):
- State goes to IDLE; PC=0; all cells=0; out_z=0; err=0.
- Resulting outputs: out_valid=0, in_ready=1, busy=0.
- Program memory is NOT cleared by reset.
- Reset asserted mid-run aborts immediately; no partial result is presented.

States and transitions:
- IDLE: the only state in which prog_we writes memory; prog_we in any other state is silently dropped. When in_valid & in_ready: capture in_x, go to LOAD.
- LOAD, 1 cycle: cells[0..NIN-1] <= captured vector; PC <= 0; go to INIT.
- INIT, 1 cycle: cells[dst] <= 1; go to EVAL.
- EVAL, 1 cycle: cells[dst] <= NOR of the active sources.
  - nsrc=1 uses srcA; nsrc=2 uses A,B; nsrc=3 uses A,B,C.
  - nsrc=0 is treated as 1.
  - Sources are read from pre-INIT values, so a source equal to dst sees its old value (matches the crossbar, where inputs are sensed before the output is set).
  - If last=1: out_z <= the computed value; go to DONE.
  - Else if PC == PROG_DEPTH-1: treat as last and set err=1.
  - Else PC <= PC+1; go to INIT.
- DONE: out_valid=1 and out_z is held stable until out_ready. On out_valid & out_ready go to IDLE; in_ready rises the next cycle. No new input is accepted in the acceptance cycle.

Timing and write rules:
- Latency from the in_valid&in_ready edge to out_valid = 2 + 2N cycles for an N-instruction program.
- dst may be any cell, including input cells, which may be overwritten. Cells are not re-zeroed between runs except for inputs reloaded in LOAD.
- Simultaneous INIT/EVAL conflicts are impossible: one instruction executes at a time.

Decomposition:
Shared package nor_seq_pkg:
- Field widths CW and PW.
- Instruction field offsets (LAST, NSRC, DST, SA, SB, SC).
- State enum {IDLE, LOAD, INIT, EVAL, DONE}.
- Instruction typedef (struct).

Sub-module nor_prog_mem:
- PROG_DEPTH x IW synchronous-write memory with combinational read at PC.
- No reset.
- The sequencer owns the FSM and the cell array.

Test Plan:
1. Single NOT: program {last=1, nsrc=1, dst=8, A=0}; in_x=0x01 → out_z=0 with out_valid 4 cycles after accept. in_x=0x00 → out_z=1.
2. XOR(x0,x1) as 5 NORs:
   - n8=NOR(0,1); n9=NOR(0,8); n10=NOR(1,8); n11=NOR(9,10); n12=NOR(11) last.
   - in_x=0x01 → out_z=1 and 0x03 → out_z=0; latency 12 each.
3. Full rd84f1 NOR mapping loaded: sweep in_x 0x00..0xFF back-to-back, comparing against the golden rd84f1 function of popcount(in_x). All 256 match; err=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, out_z is unchanged, in_ready=0. Also pulse prog_we during the run → memory is unchanged and re-running gives the same out_z.
5. Missing last flag:
   - Fill all PROG_DEPTH entries with last=0 → err=1 after 2+2*PROG_DEPTH cycles and DONE is reached.
   - err persists across later runs until rst_n pulses.
6. Reset mid-EVAL of test 2: drop rst_n asynchronously → out_valid=0, busy=0, in_ready=1 immediately. Program is retained; the next run on in_x=0x02 gives out_z=1.
